// File: rtl/color_report_pkg.sv
// Shared constants, FSM states and helpers for the colour report transmitter.
package color_report_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;

    // Number of colour channels carried in one frame (R, G, B).
    localparam int NUM_CH = 3;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        EMIT_H,
        EMIT_T,
        EMIT_U,
        EMIT_SEP,
        EMIT_TERM
    } state_t;

    // Map a decimal digit 0..9 to its ASCII character.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/color_report_tx_dec3.sv
// Serial 8-bit binary to three decimal digits, one subtraction per cycle.
module dec3_digits (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       valid
);
    logic [7:0] rem_reg;
    logic [3:0] h_reg;
    logic [3:0] t_reg;
    logic       active_reg;
    logic       valid_reg;

    // Load a new value, then peel off hundreds, then tens; the leftover is units.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg    <= 8'd0;
            h_reg      <= 4'd0;
            t_reg      <= 4'd0;
            active_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else if (load) begin
            rem_reg    <= value;
            h_reg      <= 4'd0;
            t_reg      <= 4'd0;
            active_reg <= 1'b1;
            valid_reg  <= 1'b0;
        end else if (active_reg) begin
            if (rem_reg >= 8'd100) begin
                rem_reg <= rem_reg - 8'd100;
                h_reg   <= h_reg + 4'd1;
            end else if (rem_reg >= 8'd10) begin
                rem_reg <= rem_reg - 8'd10;
                t_reg   <= t_reg + 4'd1;
            end else begin
                active_reg <= 1'b0;
                valid_reg  <= 1'b1;
            end
        end
    end

    assign hundreds = h_reg;
    assign tens     = t_reg;
    assign units    = rem_reg[3:0];
    assign valid    = valid_reg;

endmodule

// File: rtl/color_report_tx.sv
// Converts an RGB triple to "R,G,B<CR>" ASCII and streams it over valid/ready.
module color_report_tx
    import color_report_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR       = ASCII_COMMA,
    parameter logic [7:0] TERM_CHAR      = ASCII_CR,
    parameter bit         SUPPRESS_ZEROS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] r_val,
    input  logic [7:0] g_val,
    input  logic [7:0] b_val,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       done
);
    state_t     state_reg, state_next;
    logic [1:0] ch_reg, ch_next;
    logic       done_reg, done_next;
    // Red goes straight into the converter on start; only green and blue wait.
    logic [7:0] g_reg, b_reg;
    logic       latch;
    logic       conv_load;
    logic [7:0] conv_value;
    logic [3:0] dig_h, dig_t, dig_u;
    logic       conv_valid;

    dec3_digits u_dec (
        .clk      (clk),
        .rst      (rst),
        .load     (conv_load),
        .value    (conv_value),
        .hundreds (dig_h),
        .tens     (dig_t),
        .units    (dig_u),
        .valid    (conv_valid)
    );

    // In IDLE the converter takes red live; on a separator it takes the next latched channel.
    assign conv_value = (state_reg == IDLE) ? r_val :
                        (ch_reg == 2'd0)    ? g_reg : b_reg;

    // Sequence conversion and emission; advance only on an accepted byte.
    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        done_next  = 1'b0;
        latch      = 1'b0;
        conv_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                // The done cycle still belongs to the previous frame.
                if (start && !done_reg) begin
                    latch      = 1'b1;
                    conv_load  = 1'b1;
                    ch_next    = 2'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_valid) begin
                    if (SUPPRESS_ZEROS && dig_h == 4'd0)
                        state_next = (dig_t == 4'd0) ? EMIT_U : EMIT_T;
                    else
                        state_next = EMIT_H;
                end
            end
            EMIT_H: if (tx_ready) state_next = EMIT_T;
            EMIT_T: if (tx_ready) state_next = EMIT_U;
            EMIT_U: begin
                if (tx_ready)
                    state_next = (ch_reg == 2'(NUM_CH - 1)) ? EMIT_TERM : EMIT_SEP;
            end
            EMIT_SEP: begin
                if (tx_ready) begin
                    conv_load  = 1'b1;
                    ch_next    = ch_reg + 2'd1;
                    state_next = CONV;
                end
            end
            EMIT_TERM: begin
                if (tx_ready) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, channel index, done pulse and latched channel values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ch_reg    <= 2'd0;
            done_reg  <= 1'b0;
            g_reg     <= 8'd0;
            b_reg     <= 8'd0;
        end else begin
            state_reg <= state_next;
            ch_reg    <= ch_next;
            done_reg  <= done_next;
            if (latch) begin
                g_reg <= g_val;
                b_reg <= b_val;
            end
        end
    end

    // Byte on offer is a pure function of held state, so it stays stable under back-pressure.
    always_comb begin
        tx_data = 8'h00;
        case (state_reg)
            EMIT_H:    tx_data = digit_ascii(dig_h);
            EMIT_T:    tx_data = digit_ascii(dig_t);
            EMIT_U:    tx_data = digit_ascii(dig_u);
            EMIT_SEP:  tx_data = SEP_CHAR;
            EMIT_TERM: tx_data = TERM_CHAR;
            default:   tx_data = 8'h00;
        endcase
    end

    assign tx_valid = (state_reg == EMIT_H) || (state_reg == EMIT_T) ||
                      (state_reg == EMIT_U) || (state_reg == EMIT_SEP) ||
                      (state_reg == EMIT_TERM);
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_color_report_tx.sv
// Directed bench: two instances (zero suppression on and off), frames checked byte by byte.
module tb_color_report_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] r_val, g_val, b_val;
    logic       tx_ready;
    logic       busy0, tx_valid0, done0;
    logic [7:0] tx_data0;
    logic       busy1, tx_valid1, done1;
    logic [7:0] tx_data1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] nr, ng, nb;

    always #5 clk = ~clk;

    color_report_tx dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .r_val(r_val), .g_val(g_val), .b_val(b_val),
        .busy(busy0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready), .done(done0)
    );

    color_report_tx #(.SUPPRESS_ZEROS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .r_val(r_val), .g_val(g_val), .b_val(b_val),
        .busy(busy1), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic g_valid(input bit sel);
        return sel ? tx_valid1 : tx_valid0;
    endfunction
    function automatic logic [7:0] g_data(input bit sel);
        return sel ? tx_data1 : tx_data0;
    endfunction
    function automatic logic g_busy(input bit sel);
        return sel ? busy1 : busy0;
    endfunction
    function automatic logic g_done(input bit sel);
        return sel ? done1 : done0;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    task automatic do_start(input bit sel, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(negedge clk);
        r_val = r; g_val = g; b_val = b;
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        chk("busy_after_start", g_busy(sel), 1'b1);
    endtask

    // Collect one frame against exp_q; optional stall, mid-frame start pulse, restart in done cycle.
    task automatic recv(input bit sel, input int stall_at, input int pulse_at, input bit restart);
        int  idx = 0;
        int  cyc = 0;
        bit  stalled = 1'b0;
        while (idx < exp_q.size() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            set_start(sel, 1'b0);
            if (g_valid(sel)) begin
                if (idx == pulse_at) begin
                    r_val = 8'd77; g_val = 8'd88; b_val = 8'd99;
                    set_start(sel, 1'b1);
                end
                if (idx == stall_at && !stalled) begin
                    stalled  = 1'b1;
                    tx_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        chk("stall_valid", g_valid(sel), 1'b1);
                        chk("stall_data", g_data(sel), exp_q[idx]);
                    end
                    tx_ready = 1'b1;
                end
                chk($sformatf("byte%0d", idx), g_data(sel), exp_q[idx]);
                idx++;
            end
        end
        if (idx < exp_q.size()) chk("frame_timeout", idx, exp_q.size());
        @(negedge clk);
        chk("done_pulse", g_done(sel), 1'b1);
        chk("busy_at_done", g_busy(sel), 1'b0);
        if (restart) begin
            r_val = nr; g_val = ng; b_val = nb;
            set_start(sel, 1'b1);
            @(negedge clk);
            chk("start_in_done_ignored", g_busy(sel), 1'b0);
            chk("done_one_cycle", g_done(sel), 1'b0);
            @(negedge clk);
            set_start(sel, 1'b0);
            chk("start_after_done", g_busy(sel), 1'b1);
        end else begin
            @(negedge clk);
            chk("done_one_cycle", g_done(sel), 1'b0);
        end
    endtask

    initial begin
        int seen;
        int cyc;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        r_val = 8'd0; g_val = 8'd0; b_val = 8'd0; tx_ready = 1'b1;
        nr = 8'd0; ng = 8'd0; nb = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy0", busy0, 1'b0);
        chk("rst_valid0", tx_valid0, 1'b0);
        chk("rst_data0", tx_data0, 8'h00);
        chk("rst_done0", done0, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_valid1", tx_valid1, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // All zeros collapses to single "0" fields.
        exp_q = '{8'h30, 8'h2C, 8'h30, 8'h2C, 8'h30, 8'h0D};
        do_start(1'b0, 8'd0, 8'd0, 8'd0);
        recv(1'b0, -1, -1, 1'b0);
        $display("frame 0,0,0 checked, errors so far %0d", errors);

        // 255,100,7 with a mid-frame start pulse, then a start held from the done cycle.
        exp_q = '{8'h32, 8'h35, 8'h35, 8'h2C, 8'h31, 8'h30, 8'h30, 8'h2C, 8'h37, 8'h0D};
        nr = 8'd9; ng = 8'd10; nb = 8'd99;
        do_start(1'b0, 8'd255, 8'd100, 8'd7);
        recv(1'b0, -1, 3, 1'b1);
        $display("frame 255,100,7 checked, errors so far %0d", errors);

        // 9,10,99 (started from the done cycle above) with a 5-cycle stall on byte 2.
        exp_q = '{8'h39, 8'h2C, 8'h31, 8'h30, 8'h2C, 8'h39, 8'h39, 8'h0D};
        recv(1'b0, 1, -1, 1'b0);
        $display("frame 9,10,99 checked, errors so far %0d", errors);

        // Fixed three-digit fields.
        exp_q = '{8'h30, 8'h30, 8'h35, 8'h2C, 8'h30, 8'h30, 8'h30, 8'h2C,
                  8'h30, 8'h34, 8'h32, 8'h0D};
        do_start(1'b1, 8'd5, 8'd0, 8'd42);
        recv(1'b1, -1, -1, 1'b0);
        chk("dut0_idle_during_dut1", busy0, 1'b0);
        $display("frame 5,0,42 (no suppression) checked, errors so far %0d", errors);

        // Reset while the 4th byte is on offer.
        do_start(1'b0, 8'd255, 8'd100, 8'd7);
        seen = 0;
        cyc  = 0;
        while (seen < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (tx_valid0) seen++;
        end
        chk("fourth_byte_reached", seen, 4);
        chk("fourth_byte_data", tx_data0, 8'h2C);
        rst = 1'b1;
        #1;
        chk("midrst_valid", tx_valid0, 1'b0);
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_done", done0, 1'b0);
        chk("midrst_data", tx_data0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-frame reset checked, errors so far %0d", errors);

        exp_q = '{8'h31, 8'h2C, 8'h32, 8'h2C, 8'h33, 8'h0D};
        do_start(1'b0, 8'd1, 8'd2, 8'd3);
        recv(1'b0, -1, -1, 1'b0);
        $display("frame 1,2,3 checked, errors so far %0d", errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
